// File: rtl/rgb_decoder.sv
// Two-stage decoder from 24-bit RGB words back to 3-bit colour codes, with valid/ready on both sides.
// Define RGB_DECODER_THRESHOLD_EN to snap non-exact words to the nearest code instead of zero.
module rgb_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      rgb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       colour,
  output logic             match,
  input  logic             clr,
  output logic [CNT_W-1:0] mismatch_cnt
);

  logic       advance;
  logic       live;
  logic       s1_valid;
  logic [2:0] s1_bit;
  logic [2:0] s1_ok;
  logic [2:0] ch_bit;
  logic [2:0] ch_ok;
  logic [2:0] colour_next;
  logic       match_next;

  // live keeps in_ready low while rst_n is asserted, since advance alone would be high then
  assign advance  = !out_valid || out_ready;
  assign in_ready = live && enable && advance;

  always_comb begin
    ch_bit = 3'b000;
    ch_ok  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      ch_ok[i] = (rgb[8*i +: 8] == 8'h00) || (rgb[8*i +: 8] == 8'hFF);
`ifdef RGB_DECODER_THRESHOLD_EN
      ch_bit[i] = rgb[8*i + 7];
`else
      ch_bit[i] = (rgb[8*i +: 8] == 8'hFF);
`endif
    end
  end

  always_comb begin
    match_next = &s1_ok;
`ifdef RGB_DECODER_THRESHOLD_EN
    colour_next = s1_bit;
`else
    colour_next = match_next ? s1_bit : 3'b000;
`endif
  end

  // Both stages move together only when the output slot can take new data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live      <= 1'b0;
      s1_valid  <= 1'b0;
      s1_bit    <= 3'b000;
      s1_ok     <= 3'b000;
      out_valid <= 1'b0;
      colour    <= 3'b000;
      match     <= 1'b0;
    end else begin
      live <= 1'b1;
      if (advance) begin
        s1_valid  <= in_valid && in_ready;
        s1_bit    <= ch_bit;
        s1_ok     <= ch_ok;
        out_valid <= s1_valid;
        colour    <= colour_next;
        match     <= match_next;
      end
    end
  end

  // Clear takes priority; the count sticks at all-ones rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_cnt <= '0;
    end else if (clr) begin
      mismatch_cnt <= '0;
    end else if (out_valid && out_ready && !match && (mismatch_cnt != {CNT_W{1'b1}})) begin
      mismatch_cnt <= mismatch_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rgb_decoder.sv
// Self-checking bench for rgb_decoder: directed scenarios plus a randomized run against a queue model.
// Builds with or without RGB_DECODER_THRESHOLD_EN; the reference decode follows the same macro.
module tb_rgb_decoder;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             in_valid;
  logic             in_ready;
  logic [23:0]      rgb;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       colour;
  logic             match;
  logic             clr;
  logic [CNT_W-1:0] mismatch_cnt;

  int errors;
  int checks;

  rgb_decoder #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .rgb          (rgb),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .colour       (colour),
    .match        (match),
    .clr          (clr),
    .mismatch_cnt (mismatch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode from the channel rules: returns {match, colour}
  function automatic logic [3:0] ref_decode(input logic [23:0] w);
    logic [7:0] b;
    logic [2:0] c;
    logic       legal;
    legal = 1'b1;
    c = 3'b000;
    for (int i = 0; i < 3; i++) begin
      b = w[8*i +: 8];
      if (b != 8'h00 && b != 8'hFF) legal = 1'b0;
      c[i] = (b >= 8'h80);
    end
`ifndef RGB_DECODER_THRESHOLD_EN
    if (!legal) c = 3'b000;
`endif
    return {legal, c};
  endfunction

  function automatic logic [23:0] code_word(input logic [2:0] k);
    return {{8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  task automatic cycle_end();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clr = 1'b0;
    rgb = 24'h0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    cycle_end();
    cycle_end();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    clr = 1'b0;
    rgb = 24'hFFFFFF;
    #1;
    checks += 5;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (colour !== 3'd0) begin errors++; $display("[TB] FAIL reset_colour: got %0d expected 0", colour); end
    if (match !== 1'b0) begin errors++; $display("[TB] FAIL reset_match: got %b expected 0", match); end
    if (mismatch_cnt !== '0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", mismatch_cnt); end
    apply_reset();
  endtask

  task automatic test_codes();
    logic [2:0] k;
    apply_reset();
    enable = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8);
      k = 3'(c);
      rgb = (c < 8) ? code_word(k) : 24'h0;
      @(negedge clk);
      if (c < 8) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL codes_in_ready c=%0d: got %b expected 1", c, in_ready); end
      end
      checks++;
      if (out_valid !== (c >= 2 && c < 10)) begin
        errors++; $display("[TB] FAIL codes_out_valid c=%0d: got %b expected %b", c, out_valid, (c >= 2 && c < 10));
      end
      if (c >= 2 && c < 10) begin
        checks += 2;
        if (colour !== 3'(c - 2)) begin errors++; $display("[TB] FAIL codes_colour c=%0d: got %0d expected %0d", c, colour, c - 2); end
        if (match !== 1'b1) begin errors++; $display("[TB] FAIL codes_match c=%0d: got %b expected 1", c, match); end
      end
      cycle_end();
    end
    checks++;
    if (mismatch_cnt !== '0) begin errors++; $display("[TB] FAIL codes_cnt: got %0d expected 0", mismatch_cnt); end
  endtask

  task automatic test_illegal();
    logic [3:0] e;
    apply_reset();
    enable = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    rgb = 24'h123456;
    e = ref_decode(rgb);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL illegal_in_ready: got %b expected 1", in_ready); end
    cycle_end();
    in_valid = 1'b0;
    cycle_end();
    @(negedge clk);
    checks += 4;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL illegal_out_valid: got %b expected 1", out_valid); end
    if (colour !== e[2:0]) begin errors++; $display("[TB] FAIL illegal_colour: got %0d expected %0d", colour, e[2:0]); end
    if (match !== 1'b0) begin errors++; $display("[TB] FAIL illegal_match: got %b expected 0", match); end
    if (mismatch_cnt !== 2'd0) begin errors++; $display("[TB] FAIL illegal_cnt_before: got %0d expected 0", mismatch_cnt); end
    cycle_end();
    @(negedge clk);
    checks++;
    if (mismatch_cnt !== 2'd1) begin errors++; $display("[TB] FAIL illegal_cnt_after: got %0d expected 1", mismatch_cnt); end
    cycle_end();
    in_valid = 1'b1;
    rgb = 24'h00FF00;
    cycle_end();
    in_valid = 1'b0;
    cycle_end();
    @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL legal_out_valid: got %b expected 1", out_valid); end
    if (colour !== 3'd2) begin errors++; $display("[TB] FAIL legal_colour: got %0d expected 2", colour); end
    if (match !== 1'b1) begin errors++; $display("[TB] FAIL legal_match: got %b expected 1", match); end
    cycle_end();
    @(negedge clk);
    checks++;
    if (mismatch_cnt !== 2'd1) begin errors++; $display("[TB] FAIL legal_cnt: got %0d expected 1", mismatch_cnt); end
  endtask

  task automatic test_threshold();
    logic [3:0] e;
    apply_reset();
    enable = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    rgb = 24'h807FC0;
    e = ref_decode(rgb);
    cycle_end();
    in_valid = 1'b0;
    cycle_end();
    @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL thresh_out_valid: got %b expected 1", out_valid); end
    if (colour !== e[2:0]) begin errors++; $display("[TB] FAIL thresh_colour: got %0d expected %0d", colour, e[2:0]); end
    if (match !== 1'b0) begin errors++; $display("[TB] FAIL thresh_match: got %b expected 0", match); end
    cycle_end();
    @(negedge clk);
    checks++;
    if (mismatch_cnt !== 2'd1) begin errors++; $display("[TB] FAIL thresh_cnt: got %0d expected 1", mismatch_cnt); end
  endtask

  task automatic test_backpressure();
    logic [23:0] w [3];
    logic [3:0]  e;
    bit          sent2;
    int          got;
    w[0] = 24'hFF0000;
    w[1] = 24'h00FFFF;
    w[2] = 24'hFFFFFF;
    apply_reset();
    enable = 1'b1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    rgb = w[0];
    cycle_end();
    rgb = w[1];
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_second_accept: got %b expected 1", in_ready); end
    cycle_end();
    rgb = w[2];
    e = ref_decode(w[0]);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks += 3;
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready c=%0d: got %b expected 0", c, in_ready); end
      if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_valid c=%0d: got %b expected 1", c, out_valid); end
      if (colour !== e[2:0]) begin errors++; $display("[TB] FAIL bp_hold_colour c=%0d: got %0d expected %0d", c, colour, e[2:0]); end
      cycle_end();
    end
    out_ready = 1'b1;
    sent2 = 1'b0;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) sent2 = 1'b1;
      if (out_valid) begin
        checks++;
        if (got >= 3) begin
          errors++; $display("[TB] FAIL bp_extra_output: got colour %0d expected no output", colour);
        end else begin
          e = ref_decode(w[got]);
          if (colour !== e[2:0]) begin errors++; $display("[TB] FAIL bp_order idx=%0d: got %0d expected %0d", got, colour, e[2:0]); end
        end
        got++;
      end
      cycle_end();
      if (sent2) in_valid = 1'b0;
    end
    checks++;
    if (got != 3) begin errors++; $display("[TB] FAIL bp_delivered: got %0d expected 3", got); end
  endtask

  task automatic test_saturation();
    apply_reset();
    enable = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      in_valid = (c < 6);
      rgb = {8'($urandom_range(1, 254)), 16'($urandom)};
      clr = (c == 7);
      @(negedge clk);
      if (c >= 3 && c <= 7) begin
        checks++;
        if (mismatch_cnt !== 2'((c - 2) > CNT_MAX ? CNT_MAX : (c - 2))) begin
          errors++; $display("[TB] FAIL sat_cnt c=%0d: got %0d expected %0d", c, mismatch_cnt, ((c - 2) > CNT_MAX ? CNT_MAX : (c - 2)));
        end
      end
      if (c == 7) begin
        checks++;
        if (!(out_valid === 1'b1 && match === 1'b0)) begin
          errors++; $display("[TB] FAIL sat_sixth_xfer: got valid=%b match=%b expected valid=1 match=0", out_valid, match);
        end
      end
      if (c == 8) begin
        checks++;
        if (mismatch_cnt !== 2'd0) begin errors++; $display("[TB] FAIL sat_clr: got %0d expected 0", mismatch_cnt); end
      end
      cycle_end();
    end
    clr = 1'b0;
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    enable = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    rgb = 24'h0A0B0C;
    cycle_end();
    in_valid = 1'b0;
    repeat (3) cycle_end();
    checks++;
    if (mismatch_cnt !== 2'd1) begin errors++; $display("[TB] FAIL mid_cnt_pre: got %0d expected 1", mismatch_cnt); end
    out_ready = 1'b0;
    in_valid = 1'b1;
    rgb = 24'hFF00FF;
    cycle_end();
    rgb = 24'h00FFFF;
    cycle_end();
    in_valid = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_inflight: got %b expected 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_valid: got %b expected 0", out_valid); end
    if (mismatch_cnt !== 2'd0) begin errors++; $display("[TB] FAIL mid_async_cnt: got %0d expected 0", mismatch_cnt); end
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_ready: got %b expected 0", in_ready); end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    cycle_end();
    cycle_end();
    in_valid = 1'b1;
    rgb = 24'h0000FF;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_accept: got %b expected 1", in_ready); end
    cycle_end();
    in_valid = 1'b0;
    for (int c = 1; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (c == 2)) begin errors++; $display("[TB] FAIL mid_out_valid c=%0d: got %b expected %b", c, out_valid, (c == 2)); end
      if (c == 2) begin
        checks += 2;
        if (colour !== 3'd1) begin errors++; $display("[TB] FAIL mid_colour: got %0d expected 1", colour); end
        if (match !== 1'b1) begin errors++; $display("[TB] FAIL mid_match: got %b expected 1", match); end
      end
      cycle_end();
    end
  endtask

  task automatic test_random();
    logic [3:0]  q[$];
    logic [3:0]  front;
    logic [2:0]  k;
    logic [23:0] w;
    int          cnt_model;
    int          sel;
    bit          in_x;
    bit          out_x;
    apply_reset();
    cnt_model = 0;
    for (int n = 0; n < 420; n++) begin
      k = 3'($urandom);
      w = code_word(k);
      sel = $urandom_range(0, 3);
      if (sel == 2) w = 24'($urandom);
      if (sel == 3) w[8*$urandom_range(0, 2) +: 8] = 8'($urandom);
      rgb = w;
      if (n < 400) begin
        in_valid = 1'($urandom_range(0, 1));
        enable = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        clr = ($urandom_range(0, 19) == 0);
      end else begin
        in_valid = 1'b0;
        enable = 1'b0;
        out_ready = 1'b1;
        clr = 1'b0;
      end
      @(negedge clk);
      checks += 2;
      if (in_ready !== (enable && (!out_valid || out_ready))) begin
        errors++; $display("[TB] FAIL rnd_in_ready n=%0d: got %b expected %b", n, in_ready, (enable && (!out_valid || out_ready)));
      end
      if (mismatch_cnt !== 2'(cnt_model)) begin
        errors++; $display("[TB] FAIL rnd_cnt n=%0d: got %0d expected %0d", n, mismatch_cnt, cnt_model);
      end
      front = 4'h0;
      if (out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("[TB] FAIL rnd_spurious n=%0d: got colour %0d expected no output", n, colour);
        end else begin
          front = q[0];
          if ({match, colour} !== front) begin
            errors++; $display("[TB] FAIL rnd_data n=%0d: got match=%b colour=%0d expected match=%b colour=%0d", n, match, colour, front[3], front[2:0]);
          end
        end
      end
      in_x = in_valid && in_ready;
      out_x = (out_valid === 1'b1) && out_ready && (q.size() != 0);
      @(posedge clk);
      if (clr) cnt_model = 0;
      else if (out_x && !front[3] && cnt_model < CNT_MAX) cnt_model++;
      if (out_x) void'(q.pop_front());
      if (in_x) q.push_back(ref_decode(w));
      #1;
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("[TB] FAIL rnd_drain: got %0d words left expected 0", q.size()); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    enable = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clr = 1'b0;
    rgb = 24'h0;
    @(posedge clk);
    #2;
    test_reset();
    test_codes();
    test_illegal();
    test_threshold();
    test_backpressure();
    test_saturation();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
